// File: rtl/div_seq.sv
// Sequential signed restoring divider (radix 2, one quotient bit per cycle).
// Operates on magnitudes and restores the signs afterwards; the quotient truncates toward zero.
module div_seq #(
  parameter int DIVIDEND_W = 43,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DIVIDEND_W-1:0] quot_o,
  output logic [DIVISOR_W-1:0]  rem_o,
  output logic                  dz_o,
  output logic                  ovf_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] Q_MAX    = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] Q_MIN    = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DIVIDEND_W-1:0] q_sh;
  logic [DIVISOR_W-1:0]  r_mag;
  logic [DIVISOR_W-1:0]  d_mag;
  logic                  sign_a;
  logic                  sign_b;
  logic [CNT_W-1:0]      cnt;

  logic                  accept;
  logic                  div_zero;
  logic [DIVIDEND_W-1:0] a_abs;
  logic [DIVISOR_W-1:0]  b_abs;
  logic [DIVISOR_W:0]    trial;
  logic                  ge;
  logic [DIVISOR_W-1:0]  sub;

  // Two's-complement negation read as unsigned gives |MIN| = 2^(W-1) exactly.
  assign accept   = valid_i && (state == IDLE);
  assign div_zero = (divisor_i == {DIVISOR_W{1'b0}});
  assign a_abs    = dividend_i[DIVIDEND_W-1] ? -dividend_i : dividend_i;
  assign b_abs    = divisor_i[DIVISOR_W-1] ? -divisor_i : divisor_i;

  // The partial remainder is below |divisor|, so the shifted trial value fits DIVISOR_W+1 bits.
  assign trial = {r_mag, q_sh[DIVIDEND_W-1]};
  assign ge    = (trial >= {1'b0, d_mag});
  assign sub   = trial[DIVISOR_W-1:0] - d_mag;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = div_zero ? DONE : CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          next_state = FIX;
        end else begin
          next_state = CALC;
        end
      end
      FIX:  next_state = DONE;
      DONE: begin
        if (ready_i) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state)
      IDLE:    ready_o = 1'b1;
      DONE:    valid_o = 1'b1;
      default: begin
        ready_o = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

  // Operand capture, restoring iteration and sign fix-up
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_sh   <= {DIVIDEND_W{1'b0}};
      r_mag  <= {DIVISOR_W{1'b0}};
      d_mag  <= {DIVISOR_W{1'b0}};
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= {CNT_W{1'b0}};
      quot_o <= {DIVIDEND_W{1'b0}};
      rem_o  <= {DIVISOR_W{1'b0}};
      dz_o   <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_sh   <= a_abs;
            d_mag  <= b_abs;
            r_mag  <= {DIVISOR_W{1'b0}};
            sign_a <= dividend_i[DIVIDEND_W-1];
            sign_b <= divisor_i[DIVISOR_W-1];
            cnt    <= {CNT_W{1'b0}};
            if (div_zero) begin
              quot_o <= dividend_i[DIVIDEND_W-1] ? Q_MIN : Q_MAX;
              rem_o  <= {DIVISOR_W{1'b0}};
              dz_o   <= 1'b1;
              ovf_o  <= 1'b0;
            end
          end
        end
        CALC: begin
          q_sh  <= {q_sh[DIVIDEND_W-2:0], ge};
          r_mag <= ge ? sub : trial[DIVISOR_W-1:0];
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          // A positive quotient of magnitude 2^(W-1) only arises from MIN / -1.
          quot_o <= (sign_a ^ sign_b) ? -q_sh : q_sh;
          rem_o  <= sign_a ? -r_mag : r_mag;
          dz_o   <= 1'b0;
          ovf_o  <= ~(sign_a ^ sign_b) & q_sh[DIVIDEND_W-1];
        end
        DONE: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor pops them on each handshake.
module tb_div_seq;

  localparam logic [42:0] Q_MAX = 43'h3FF_FFFF_FFFF;
  localparam logic [42:0] Q_MIN = 43'h400_0000_0000;

  typedef struct packed {
    logic [42:0] q;
    logic [17:0] r;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [42:0] dividend = 43'd0;
  logic [17:0] divisor = 18'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [42:0] quot_o;
  logic [17:0] rem_o;
  logic        dz_o;
  logic        ovf_o;

  exp_t sb[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  div_seq u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .dz_o       (dz_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input longint q, input longint r, input bit dz, input bit ovf);
    exp_t e;
    e.q = q[42:0];
    e.r = r[17:0];
    e.dz = dz;
    e.ovf = ovf;
    return e;
  endfunction

  // Reference model for random operands: SV signed division truncates toward zero.
  function automatic exp_t model(input logic signed [42:0] a, input logic signed [17:0] b);
    exp_t e;
    logic signed [42:0] bb;
    logic signed [42:0] qq;
    logic signed [42:0] rr;
    bb = b;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    if (b == 18'sd0) begin
      e.q = a[42] ? Q_MIN : Q_MAX;
      e.r = 18'd0;
      e.dz = 1'b1;
    end else if (a == $signed(Q_MIN) && b == -18'sd1) begin
      e.q = Q_MIN;
      e.r = 18'd0;
      e.ovf = 1'b1;
    end else begin
      qq = a / bb;
      rr = a % bb;
      e.q = qq;
      e.r = rr[17:0];
    end
    return e;
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {63'd0, valid_o}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quot", {21'd0, quot_o}, {21'd0, mon_e.q});
        check("rem", {46'd0, rem_o}, {46'd0, mon_e.r});
        check("dz", {63'd0, dz_o}, {63'd0, mon_e.dz});
        check("ovf", {63'd0, ovf_o}, {63'd0, mon_e.ovf});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_o) check("ready_timeout", {63'd0, ready_o}, 64'd1);
  endtask

  // Issue one operand pair; returns once valid_o is high (or the bound expires).
  task automatic do_op(input longint a, input longint b, input exp_t e, input int exp_lat);
    int lat;
    wait_ready();
    @(negedge clk);
    dividend = a[42:0];
    divisor  = b[17:0];
    valid_i  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid_o) check("valid_timeout", {63'd0, valid_o}, 64'd1);
    else if (exp_lat > 0) check("latency", lat, exp_lat);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [31:0] r32;
    longint      ra;
    longint      rb;
    int          stale;
    int          n;

    #1;
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_quot", {21'd0, quot_o}, 64'd0);
    check("rst_flags", {62'd0, dz_o, ovf_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(20000, 200, mk(100, 0, 1'b0, 1'b0), 45);
    do_op(-7, 2, mk(-3, -1, 1'b0, 1'b0), 45);
    do_op(7, -2, mk(-3, 1, 1'b0, 1'b0), 45);
    do_op(-7, -2, mk(3, -1, 1'b0, 1'b0), 45);
    do_op(7, 2, mk(3, 1, 1'b0, 1'b0), 45);
    do_op(1234, 0, mk(64'h3FF_FFFF_FFFF, 0, 1'b1, 1'b0), 1);
    do_op(-5, 0, mk(64'h400_0000_0000, 0, 1'b1, 1'b0), 1);
    do_op(-64'sd4398046511104, -1, mk(64'h400_0000_0000, 0, 1'b0, 1'b1), 45);
    do_op(-64'sd4398046511104, 1, mk(-64'sd4398046511104, 0, 1'b0, 1'b0), 45);

    // Back-pressure in DONE
    wait_ready();
    ready_i = 1'b0;
    do_op(7, 2, mk(3, 1, 1'b0, 1'b0), 45);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {63'd0, valid_o}, 64'd1);
      check("bp_ready", {63'd0, ready_o}, 64'd0);
      check("bp_quot", {21'd0, quot_o}, 64'd3);
      check("bp_rem", {46'd0, rem_o}, 64'd1);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    check("bp_hold_valid", {63'd0, valid_o}, 64'd1);
    @(posedge clk);
    #1;
    check("retire_valid", {63'd0, valid_o}, 64'd0);
    check("retire_ready", {63'd0, ready_o}, 64'd1);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 43'd20000;
    divisor  = 18'd200;
    valid_i  = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", {63'd0, ready_o}, 64'd1);
    check("arst_valid", {63'd0, valid_o}, 64'd0);
    check("arst_quot", {21'd0, quot_o}, 64'd0);
    check("arst_rem", {46'd0, rem_o}, 64'd0);
    check("arst_flags", {62'd0, dz_o, ovf_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid_o) stale++;
    end
    check("stale_valid", stale, 0);
    do_op(100, 7, mk(14, 2, 1'b0, 1'b0), 45);

    // Random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom, $urandom};
      r32 = $urandom;
      ra = longint'($signed(r64[42:0]));
      if (i % 4 == 0) rb = longint'($urandom_range(0, 15)) * ((r32[31]) ? -1 : 1);
      else rb = longint'($signed(r32[17:0]));
      do_op(ra, rb, model(r64[42:0], rb[17:0]), (rb == 0) ? 1 : 45);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
